// File: rtl/logic_gate_checker.sv
// Stimulus/response checker for a two-input gate block: walks {a,b} through
// 00..11 REPEAT times, compares all seven gate outputs against a truth table.
module logic_gate_checker #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned REPEAT        = 1,
  parameter int unsigned ERR_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             a,
  output logic             b,
  input  logic             and_out,
  input  logic             nand_out,
  input  logic             or_out,
  input  logic             nor_out,
  input  logic             xor_out,
  input  logic             xnor_out,
  input  logic             not_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [1:0]       first_fail_vec,
  output logic [6:0]       first_fail_mask,
  output logic [2:0]       state_dbg
);

  typedef enum logic [2:0] {IDLE, DRIVE, SETTLE, CHECK, DONE} state_t;

  state_t     state;
  logic [1:0] vec;
  logic [7:0] pass_idx;
  logic [7:0] settle_cnt;
  logic       fail_seen;

  logic [6:0]       expected;
  logic [6:0]       sampled;
  logic [6:0]       mismatch;
  logic [ERR_W-1:0] err_next;
  logic             last_vec;

  assign state_dbg = state;

  always_comb begin
    expected = {a & b, ~(a & b), a | b, ~(a | b), a ^ b, ~(a ^ b), ~a};
    sampled  = {and_out, nand_out, or_out, nor_out, xor_out, xnor_out, not_out};
    mismatch = expected ^ sampled;
    // One increment per failing vector, sticking at the all-ones value.
    err_next = err_count;
    if ((mismatch != 7'd0) && (err_count != {ERR_W{1'b1}}))
      err_next = err_count + ERR_W'(1);
    last_vec = (vec == 2'd3) && (pass_idx == 8'(REPEAT - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      a               <= 1'b0;
      b               <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      err_count       <= '0;
      first_fail_vec  <= 2'd0;
      first_fail_mask <= 7'd0;
      vec             <= 2'd0;
      pass_idx        <= 8'd0;
      settle_cnt      <= 8'd0;
      fail_seen       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          a <= 1'b0;
          b <= 1'b0;
          if (start) begin
            state           <= DRIVE;
            busy            <= 1'b1;
            pass            <= 1'b0;
            vec             <= 2'd0;
            pass_idx        <= 8'd0;
            err_count       <= '0;
            first_fail_vec  <= 2'd0;
            first_fail_mask <= 7'd0;
            fail_seen       <= 1'b0;
          end
        end
        DRIVE: begin
          a          <= vec[1];
          b          <= vec[0];
          settle_cnt <= 8'(SETTLE_CYCLES - 1);
          state      <= SETTLE;
        end
        SETTLE: begin
          if (settle_cnt == 8'd0) state <= CHECK;
          else                    settle_cnt <= settle_cnt - 8'd1;
        end
        CHECK: begin
          err_count <= err_next;
          if ((mismatch != 7'd0) && !fail_seen) begin
            first_fail_vec  <= {a, b};
            first_fail_mask <= mismatch;
            fail_seen       <= 1'b1;
          end
          if (vec != 2'd3) begin
            vec   <= vec + 2'd1;
            state <= DRIVE;
          end else if (!last_vec) begin
            vec      <= 2'd0;
            pass_idx <= pass_idx + 8'd1;
            state    <= DRIVE;
          end else begin
            // pass uses err_next so it is valid in the same cycle as done.
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_next == '0);
          end
        end
        DONE: begin
          a     <= 1'b0;
          b     <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_logic_gate_checker.sv
// Directed bench: four checker instances, each wrapped around a gate model with a
// selectable fault, exercising defaults, repeat/saturation, reset and fast settle.
module tb_logic_gate_checker;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // fault codes: 0 none, 1 xor stuck-at-0, 2 nand stuck-at-1, 3 not inverted
  function automatic logic [6:0] gate_model(input logic a, input logic b, input int f);
    logic [6:0] g;
    g = {a & b, ~(a & b), a | b, ~(a | b), a ^ b, ~(a ^ b), ~a};
    if (f == 1) g[2] = 1'b0;
    if (f == 2) g[5] = 1'b1;
    if (f == 3) g[0] = a;
    return g;
  endfunction

  logic       start0 = 0, start1 = 0, start3 = 0;
  int         fault0 = 0;
  logic       a0, b0, busy0, done0, pass0;
  logic [7:0] err0;
  logic [1:0] ffv0;
  logic [6:0] ffm0, g0;
  logic [2:0] st0;
  assign g0 = gate_model(a0, b0, fault0);

  logic_gate_checker u0 (
    .clk(clk), .rst(rst), .start(start0), .a(a0), .b(b0),
    .and_out(g0[6]), .nand_out(g0[5]), .or_out(g0[4]), .nor_out(g0[3]),
    .xor_out(g0[2]), .xnor_out(g0[1]), .not_out(g0[0]),
    .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
    .first_fail_vec(ffv0), .first_fail_mask(ffm0), .state_dbg(st0));

  logic       a1, b1, busy1, done1, pass1;
  logic [7:0] err1;
  logic [1:0] ffv1;
  logic [6:0] ffm1, g1;
  logic [2:0] st1;
  assign g1 = gate_model(a1, b1, 2);

  logic_gate_checker #(.REPEAT(3)) u1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1),
    .and_out(g1[6]), .nand_out(g1[5]), .or_out(g1[4]), .nor_out(g1[3]),
    .xor_out(g1[2]), .xnor_out(g1[1]), .not_out(g1[0]),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
    .first_fail_vec(ffv1), .first_fail_mask(ffm1), .state_dbg(st1));

  logic       a2, b2, busy2, done2, pass2;
  logic [0:0] err2;
  logic [1:0] ffv2;
  logic [6:0] ffm2, g2;
  logic [2:0] st2;
  assign g2 = gate_model(a2, b2, 2);

  logic_gate_checker #(.REPEAT(3), .ERR_W(1)) u2 (
    .clk(clk), .rst(rst), .start(start1), .a(a2), .b(b2),
    .and_out(g2[6]), .nand_out(g2[5]), .or_out(g2[4]), .nor_out(g2[3]),
    .xor_out(g2[2]), .xnor_out(g2[1]), .not_out(g2[0]),
    .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
    .first_fail_vec(ffv2), .first_fail_mask(ffm2), .state_dbg(st2));

  logic       a3, b3, busy3, done3, pass3;
  logic [7:0] err3;
  logic [1:0] ffv3;
  logic [6:0] ffm3, g3;
  logic [2:0] st3;
  assign g3 = gate_model(a3, b3, 3);

  logic_gate_checker #(.SETTLE_CYCLES(1)) u3 (
    .clk(clk), .rst(rst), .start(start3), .a(a3), .b(b3),
    .and_out(g3[6]), .nand_out(g3[5]), .or_out(g3[4]), .nor_out(g3[3]),
    .xor_out(g3[2]), .xnor_out(g3[1]), .not_out(g3[0]),
    .busy(busy3), .done(done3), .pass(pass3), .err_count(err3),
    .first_fail_vec(ffv3), .first_fail_mask(ffm3), .state_dbg(st3));

  function automatic logic done_of(input int idx);
    case (idx)
      0: return done0;
      1: return done1;
      2: return done2;
      default: return done3;
    endcase
  endfunction

  // Returns the cycle index (1 = cycle after the start edge) of done, or -1.
  task automatic wait_done(input int idx, input int budget, output int n);
    n = -1;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (done_of(idx)) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic pulse_start(input int idx);
    @(negedge clk);
    if (idx == 0) start0 = 1'b1; else if (idx == 1) start1 = 1'b1; else start3 = 1'b1;
    @(posedge clk);
    #1;
    start0 = 1'b0; start1 = 1'b0; start3 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({a0, b0, busy0, done0, pass0} !== 5'b0 || err0 !== 8'd0 || ffv0 !== 2'd0 || ffm0 !== 7'd0) begin
      errors++;
      $display("FAIL reset_state: got a=%b b=%b busy=%b done=%b pass=%b err=%0d ffv=%b ffm=%b, want all 0",
               a0, b0, busy0, done0, pass0, err0, ffv0, ffm0);
    end
  endtask

  task automatic test_basic();
    fault0 = 0;
    pulse_start(0);
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (n == 1) begin
        checks++;
        if (busy0 !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b want 1", busy0); end
      end
      for (int v = 0; v < 4; v++) if (n == 3 + 4 * v) begin
        checks++;
        if ({a0, b0} !== 2'(v)) begin
          errors++; $display("FAIL basic_ab_vec%0d: got %b%b want %0d", v, a0, b0, v);
        end
      end
      if (n == 16 || n == 17 || n == 18) begin
        checks++;
        if (done0 !== (n == 17)) begin
          errors++; $display("FAIL basic_done_cycle%0d: got %b want %b", n, done0, n == 17);
        end
      end
      if (n == 17) begin
        checks++;
        if (pass0 !== 1'b1 || err0 !== 8'd0 || busy0 !== 1'b0) begin
          errors++; $display("FAIL basic_result: got pass=%b err=%0d busy=%b want 1,0,0", pass0, err0, busy0);
        end
      end
      if (n == 18) begin
        checks++;
        if ({a0, b0} !== 2'b00 || st0 !== 3'd0) begin
          errors++; $display("FAIL basic_idle_after: got ab=%b%b state=%0d want 00, 0", a0, b0, st0);
        end
      end
    end
  endtask

  task automatic test_xor_fault();
    int n;
    fault0 = 1;
    pulse_start(0);
    wait_done(0, 40, n);
    checks++;
    if (n != 17) begin errors++; $display("FAIL xor_done_latency: got %0d want 17", n); end
    checks++;
    if (err0 !== 8'd2 || ffv0 !== 2'b01 || ffm0 !== 7'b0000100 || pass0 !== 1'b0) begin
      errors++; $display("FAIL xor_result: got err=%0d ffv=%b ffm=%b pass=%b want 2, 01, 0000100, 0",
                         err0, ffv0, ffm0, pass0);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (err0 !== 8'd2 || ffv0 !== 2'b01 || pass0 !== 1'b0) begin
      errors++; $display("FAIL xor_hold: got err=%0d ffv=%b pass=%b want 2, 01, 0", err0, ffv0, pass0);
    end
  endtask

  task automatic test_repeat_saturate();
    int n;
    pulse_start(1);
    wait_done(1, 80, n);
    checks++;
    if (n != 49) begin errors++; $display("FAIL repeat_done_latency: got %0d want 49", n); end
    checks++;
    if (err1 !== 8'd3 || ffv1 !== 2'b11 || ffm1 !== 7'b0100000 || pass1 !== 1'b0) begin
      errors++; $display("FAIL repeat_result: got err=%0d ffv=%b ffm=%b pass=%b want 3, 11, 0100000, 0",
                         err1, ffv1, ffm1, pass1);
    end
    checks++;
    if (done2 !== 1'b1 || err2 !== 1'b1 || pass2 !== 1'b0) begin
      errors++; $display("FAIL saturate_result: got done=%b err=%0d pass=%b want 1, 1, 0", done2, err2, pass2);
    end
  endtask

  task automatic test_reset_mid_run();
    int n;
    fault0 = 1;
    pulse_start(0);
    repeat (10) @(negedge clk);
    checks++;
    if (err0 !== 8'd1 || {a0, b0} !== 2'b10) begin
      errors++; $display("FAIL rst_pre: got err=%0d ab=%b%b want 1, 10", err0, a0, b0);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({a0, b0} !== 2'b00 || busy0 !== 1'b0 || err0 !== 8'd0 || ffv0 !== 2'd0 || ffm0 !== 7'd0) begin
      errors++; $display("FAIL rst_mid_run: got ab=%b%b busy=%b err=%0d ffv=%b ffm=%b want 00,0,0,00,0",
                         a0, b0, busy0, err0, ffv0, ffm0);
    end
    rst = 1'b0;
    fault0 = 0;
    pulse_start(0);
    wait_done(0, 40, n);
    checks++;
    if (n != 17 || pass0 !== 1'b1) begin
      errors++; $display("FAIL rst_rerun: got done at %0d pass=%b want 17, 1", n, pass0);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    fault0 = 0;
    pulse_start(0);
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == 5) start0 = 1'b1;
      if (i == 6) start0 = 1'b0;
      if (done0 && n < 0) n = i;
    end
    checks++;
    if (n != 17) begin errors++; $display("FAIL ignored_start: got done at %0d want 17", n); end
    // Now hold start through a run and into the next.
    @(negedge clk);
    start0 = 1'b1;
    @(posedge clk);
    for (int i = 1; i <= 19; i++) begin
      @(negedge clk);
      if (i == 17) begin
        checks++;
        if (done0 !== 1'b1) begin errors++; $display("FAIL held_done: got %b want 1", done0); end
      end
      if (i == 18) begin
        checks++;
        if (busy0 !== 1'b0 || done0 !== 1'b0 || st0 !== 3'd0) begin
          errors++; $display("FAIL held_idle: got busy=%b done=%b state=%0d want 0,0,0", busy0, done0, st0);
        end
      end
      if (i == 19) begin
        checks++;
        if (busy0 !== 1'b1 || pass0 !== 1'b0) begin
          errors++; $display("FAIL held_rearm: got busy=%b pass=%b want 1, 0", busy0, pass0);
        end
        start0 = 1'b0;
      end
    end
    wait_done(0, 30, n);
    checks++;
    if (n != 16 || pass0 !== 1'b1) begin
      errors++; $display("FAIL held_second_run: got done %0d cycles later pass=%b want 16, 1", n, pass0);
    end
  endtask

  task automatic test_fast_settle();
    int n;
    pulse_start(3);
    wait_done(3, 30, n);
    checks++;
    if (n != 13) begin errors++; $display("FAIL fast_done_latency: got %0d want 13", n); end
    checks++;
    if (err3 !== 8'd4 || ffv3 !== 2'b00 || ffm3 !== 7'b0000001 || pass3 !== 1'b0) begin
      errors++; $display("FAIL fast_result: got err=%0d ffv=%b ffm=%b pass=%b want 4, 00, 0000001, 0",
                         err3, ffv3, ffm3, pass3);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_xor_fault();
    test_repeat_saturate();
    test_reset_mid_run();
    test_back_to_back();
    test_fast_settle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
